// File: rtl/down_count_timer_if.sv
// Control and status bundle for down_count_timer.
interface down_count_timer_if #(
    parameter int unsigned WIDTH = 20
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             periodic;
    logic [WIDTH-1:0] out;
    logic             running;
    logic             tick;
    logic             done;

    modport master (
        output load, load_value, start, stop, periodic,
        input  out, running, tick, done
    );

    modport slave (
        input  load, load_value, start, stop, periodic,
        output out, running, tick, done
    );
endinterface

// File: rtl/down_count_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Emits a one-cycle tick after each terminal count.
module down_count_timer #(
    parameter int unsigned WIDTH = 20
) (
    input  logic              clk,
    input  logic              rst,
    down_count_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] reload, reload_n;
    logic             tick_q, tick_n;
    logic             running_q, done_q;

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            reload    <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            reload    <= reload_n;
            tick_q    <= tick_n;
            running_q <= (state_n == RUN);
            done_q    <= (state_n == DONE);
        end
    end

    // Next-state: load beats stop, stop beats start/counting.
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        tick_n   = 1'b0;

        if (bus.load) begin
            count_n  = bus.load_value;
            reload_n = bus.load_value;
            if (state == RUN) begin
                state_n = (bus.stop || bus.load_value == '0) ? IDLE : RUN;
            end else begin
                state_n = (bus.start && !bus.stop && bus.load_value != '0) ? RUN : IDLE;
            end
        end else if (bus.stop) begin
            if (state == RUN) begin
                state_n = IDLE;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (count != '0) begin
                            state_n = RUN;
                        end else if (reload != '0) begin
                            count_n = reload;
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (count > WIDTH'(1)) begin
                        count_n = count - WIDTH'(1);
                    end else if (count == WIDTH'(1)) begin
                        tick_n = 1'b1;
                        if (bus.periodic) begin
                            count_n = reload;
                        end else begin
                            count_n = '0;
                            state_n = DONE;
                        end
                    end else begin
                        // Zero is never decremented; park rather than underflow.
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.out     = count;
    assign bus.running = running_q;
    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_down_count_timer.sv
// Directed self-checking bench for down_count_timer: each row drives one
// cycle of controls and states the outputs expected just after that edge.
module tb_down_count_timer;
    localparam int unsigned WIDTH = 20;

    typedef struct packed {
        logic             load;
        logic [WIDTH-1:0] lv;
        logic             start;
        logic             stop;
        logic             per;
        logic [WIDTH-1:0] eo;
        logic             er;
        logic             et;
        logic             ed;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    down_count_timer_if #(.WIDTH(WIDTH)) dif ();

    down_count_timer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic l, input int lv, input logic s, input logic sp,
                               input logic p, input int eo, input logic er, input logic et,
                               input logic ed);
        vec_t r;
        r.load = l;  r.lv = WIDTH'(lv); r.start = s; r.stop = sp; r.per = p;
        r.eo = WIDTH'(eo); r.er = er; r.et = et; r.ed = ed;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t x);
        dif.load       = x.load;
        dif.load_value = x.lv;
        dif.start      = x.start;
        dif.stop       = x.stop;
        dif.periodic   = x.per;
    endtask

    task automatic test_reset();
        vec_t seq[$];
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 rst = 1'b1;
        #1;
        if ({dif.out, dif.running, dif.tick, dif.done} !== {WIDTH'(0), 3'b000}) begin
            n_fail++;
            $display("FAIL reset_initial: got out=%0h run=%b tick=%b done=%b, expected all zero",
                     dif.out, dif.running, dif.tick, dif.done);
        end
        n_checks++;
        step();
        step();
        #2 rst = 1'b0;
        // Reset mid-run: count down from 5 to 3, then pulse reset between edges.
        seq.push_back(v(1, 5, 0, 0, 0, 5, 0, 0, 0));
        seq.push_back(v(0, 0, 1, 0, 0, 5, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 4, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 3, 1, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            step();
            if ({dif.out, dif.running, dif.tick, dif.done} !== {seq[i].eo, seq[i].er, seq[i].et, seq[i].ed}) begin
                n_fail++;
                $display("FAIL reset_prerun[%0d]: got out=%0h run=%b tick=%b done=%b, expected out=%0h run=%b tick=%b done=%b",
                         i, dif.out, dif.running, dif.tick, dif.done, seq[i].eo, seq[i].er, seq[i].et, seq[i].ed);
            end
            n_checks++;
        end
        #3 rst = 1'b1;
        #1;
        if ({dif.out, dif.running, dif.tick, dif.done} !== {WIDTH'(0), 3'b000}) begin
            n_fail++;
            $display("FAIL reset_async: got out=%0h run=%b tick=%b done=%b, expected all zero",
                     dif.out, dif.running, dif.tick, dif.done);
        end
        n_checks++;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if ({dif.out, dif.running, dif.tick, dif.done} !== {WIDTH'(0), 3'b000}) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got out=%0h run=%b tick=%b done=%b, expected all zero",
                         i, dif.out, dif.running, dif.tick, dif.done);
            end
            n_checks++;
        end
    endtask

    task automatic test_one_shot();
        vec_t seq[$];
        seq.push_back(v(1, 3, 0, 0, 0, 3, 0, 0, 0));
        seq.push_back(v(0, 0, 1, 0, 0, 3, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 2, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1));
        seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
        seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
        seq.push_back(v(0, 0, 1, 0, 0, 3, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 2, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 1, 0, 2, 0, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            step();
            if ({dif.out, dif.running, dif.tick, dif.done} !== {seq[i].eo, seq[i].er, seq[i].et, seq[i].ed}) begin
                n_fail++;
                $display("FAIL one_shot[%0d]: got out=%0h run=%b tick=%b done=%b, expected out=%0h run=%b tick=%b done=%b",
                         i, dif.out, dif.running, dif.tick, dif.done, seq[i].eo, seq[i].er, seq[i].et, seq[i].ed);
            end
            n_checks++;
        end
    endtask

    task automatic test_periodic();
        vec_t seq[$];
        seq.push_back(v(1, 4, 1, 0, 1, 4, 1, 0, 0));
        for (int r = 0; r < 2; r++) begin
            seq.push_back(v(0, 0, 0, 0, 1, 3, 1, 0, 0));
            seq.push_back(v(0, 0, 0, 0, 1, 2, 1, 0, 0));
            seq.push_back(v(0, 0, 0, 0, 1, 1, 1, 0, 0));
            seq.push_back(v(0, 0, 0, 0, 1, 4, 1, 1, 0));
        end
        seq.push_back(v(1, 1, 0, 0, 1, 1, 1, 0, 0));
        for (int r = 0; r < 4; r++) seq.push_back(v(0, 0, 0, 0, 1, 1, 1, 1, 0));
        seq.push_back(v(0, 0, 0, 1, 1, 1, 0, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            step();
            if ({dif.out, dif.running, dif.tick, dif.done} !== {seq[i].eo, seq[i].er, seq[i].et, seq[i].ed}) begin
                n_fail++;
                $display("FAIL periodic[%0d]: got out=%0h run=%b tick=%b done=%b, expected out=%0h run=%b tick=%b done=%b",
                         i, dif.out, dif.running, dif.tick, dif.done, seq[i].eo, seq[i].er, seq[i].et, seq[i].ed);
            end
            n_checks++;
        end
    endtask

    task automatic test_stop_resume();
        vec_t seq[$];
        seq.push_back(v(1, 10, 1, 0, 0, 10, 1, 0, 0));
        for (int n = 9; n >= 6; n--) seq.push_back(v(0, 0, 0, 0, 0, n, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 1, 0, 6, 0, 0, 0));
        for (int r = 0; r < 5; r++) seq.push_back(v(0, 0, 0, 0, 0, 6, 0, 0, 0));
        seq.push_back(v(0, 0, 1, 0, 0, 6, 1, 0, 0));
        for (int n = 5; n >= 1; n--) seq.push_back(v(0, 0, 0, 0, 0, n, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1));
        seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
        foreach (seq[i]) begin
            drive(seq[i]);
            step();
            if ({dif.out, dif.running, dif.tick, dif.done} !== {seq[i].eo, seq[i].er, seq[i].et, seq[i].ed}) begin
                n_fail++;
                $display("FAIL stop_resume[%0d]: got out=%0h run=%b tick=%b done=%b, expected out=%0h run=%b tick=%b done=%b",
                         i, dif.out, dif.running, dif.tick, dif.done, seq[i].eo, seq[i].er, seq[i].et, seq[i].ed);
            end
            n_checks++;
        end
    endtask

    task automatic test_simultaneous();
        vec_t seq[$];
        seq.push_back(v(1, 7, 1, 0, 0, 7, 1, 0, 0));
        seq.push_back(v(1, 9, 0, 1, 0, 9, 0, 0, 0));
        seq.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 0));
        seq.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0));
        seq.push_back(v(1, 2, 1, 0, 0, 2, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0));
        seq.push_back(v(1, 20, 0, 0, 0, 20, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 19, 1, 0, 0));
        seq.push_back(v(0, 0, 1, 0, 0, 18, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 1, 0, 18, 0, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            step();
            if ({dif.out, dif.running, dif.tick, dif.done} !== {seq[i].eo, seq[i].er, seq[i].et, seq[i].ed}) begin
                n_fail++;
                $display("FAIL simultaneous[%0d]: got out=%0h run=%b tick=%b done=%b, expected out=%0h run=%b tick=%b done=%b",
                         i, dif.out, dif.running, dif.tick, dif.done, seq[i].eo, seq[i].er, seq[i].et, seq[i].ed);
            end
            n_checks++;
        end
    endtask

    task automatic test_width_boundary();
        vec_t seq[$];
        seq.push_back(v(1, 'hFFFFF, 1, 0, 0, 'hFFFFF, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 'hFFFFE, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 'hFFFFD, 1, 0, 0));
        seq.push_back(v(1, 2, 0, 0, 0, 2, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0));
        seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1));
        seq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
        foreach (seq[i]) begin
            drive(seq[i]);
            step();
            if ({dif.out, dif.running, dif.tick, dif.done} !== {seq[i].eo, seq[i].er, seq[i].et, seq[i].ed}) begin
                n_fail++;
                $display("FAIL width_boundary[%0d]: got out=%0h run=%b tick=%b done=%b, expected out=%0h run=%b tick=%b done=%b",
                         i, dif.out, dif.running, dif.tick, dif.done, seq[i].eo, seq[i].er, seq[i].et, seq[i].ed);
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_stop_resume();
        test_simultaneous();
        test_width_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
